// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions
// and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_RSH = 4'd6;
    localparam logic [3:0] OP_LSH = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between register-file read, the ALU and writeback.
interface alu_seq_if #(
    parameter int LEN = 16,
    parameter int SHW = $clog2(LEN)
);
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     opcode;
    logic [LEN-1:0] r2;
    logic [LEN-1:0] r3;
    logic [SHW-1:0] shift_bits;
    logic           out_valid;
    logic           out_ready;
    logic [LEN-1:0] r1;
    logic [3:0]     flags;
    logic           busy;

    modport master (
        output in_valid, opcode, r2, r3, shift_bits, out_ready,
        input  in_ready, out_valid, r1, flags, busy
    );

    modport slave (
        input  in_valid, opcode, r2, r3, shift_bits, out_ready,
        output in_ready, out_valid, r1, flags, busy
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle over LEN cycles.
// product/done are valid combinationally during the final step.
module alu_mul_seq #(
    parameter int LEN = 16,
    parameter int CW  = $clog2(LEN) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN-1:0]   a,
    input  logic [LEN-1:0]   b,
    output logic [2*LEN-1:0] product,
    output logic             done
);
    logic [2*LEN-1:0] acc;
    logic [2*LEN-1:0] mcand;
    logic [2*LEN-1:0] acc_nxt;
    logic [LEN-1:0]   mplier;
    logic [CW-1:0]    cnt;

    assign acc_nxt = mplier[0] ? acc + mcand : acc;
    assign product = acc_nxt;
    assign done    = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{LEN{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(LEN);
        end else if (cnt != '0) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready in, registered result + flags out. Single-cycle
// ops finish one cycle after acceptance; MUL iterates through alu_mul_seq.
module alu_seq
    import alu_pkg::*;
#(
    parameter int LEN = 16,
    parameter int SHW = $clog2(LEN)
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int MSB = LEN - 1;

    state_t           state, state_d;
    logic [LEN-1:0]   r1_q, r1_d;
    logic [3:0]       flags_q, flags_d;
    logic             mul_start, mul_done;
    logic [2*LEN-1:0] mul_prod;

    logic [LEN-1:0]   a, b, alu_r1;
    logic [SHW-1:0]   sh, lidx, ridx;
    logic [LEN:0]     sum, diff;
    logic [3:0]       alu_flags;
    logic             c, v;

    assign a  = bus.r2;
    assign b  = bus.r3;
    assign sh = bus.shift_bits;

    alu_mul_seq #(.LEN(LEN)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .product (mul_prod),
        .done    (mul_done)
    );

    // LEN is a power of two, so -sh in SHW bits is LEN-sh for any nonzero sh
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        lidx      = SHW'(0) - sh;
        ridx      = sh - 1'b1;
        alu_r1    = '0;
        c         = 1'b0;
        v         = 1'b0;
        alu_flags = '0;
        case (bus.opcode)
            OP_ADD: begin
                alu_r1 = sum[MSB:0];
                c      = sum[LEN];
                v      = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_r1 = diff[MSB:0];
                c      = diff[LEN];
                v      = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_OR:  alu_r1 = a | b;
            OP_AND: alu_r1 = a & b;
            OP_XOR: alu_r1 = a ^ b;
            OP_RSH: begin
                alu_r1 = a >> sh;
                c      = (sh != '0) && a[ridx];
            end
            OP_LSH: begin
                alu_r1 = a << sh;
                c      = (sh != '0) && a[lidx];
            end
            OP_ROR: alu_r1 = LEN'({a, a} >> sh);
            default: alu_r1 = '0;
        endcase

        alu_flags[FLAG_N] = alu_r1[MSB];
        alu_flags[FLAG_Z] = (alu_r1 == '0);
        alu_flags[FLAG_C] = c;
        alu_flags[FLAG_V] = v;

        // CMP keeps the difference-derived Z/C/V but reports a zero result
        if (bus.opcode == OP_CMP) begin
            alu_r1            = '0;
            alu_flags[FLAG_N] = 1'b0;
        end else if (bus.opcode > OP_CMP) begin
            alu_flags = '0;
        end
    end

    always_comb begin
        state_d   = state;
        r1_d      = r1_q;
        flags_d   = flags_q;
        mul_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.opcode == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_MUL;
                    end else begin
                        r1_d    = alu_r1;
                        flags_d = alu_flags;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    r1_d            = mul_prod[MSB:0];
                    flags_d[FLAG_N] = mul_prod[MSB];
                    flags_d[FLAG_Z] = (mul_prod[MSB:0] == '0);
                    flags_d[FLAG_C] = |mul_prod[2*LEN-1:LEN];
                    flags_d[FLAG_V] = 1'b0;
                    state_d         = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            r1_q    <= '0;
            flags_q <= '0;
        end else begin
            state   <= state_d;
            r1_q    <= r1_d;
            flags_q <= flags_d;
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state == S_MUL) || (state == S_DONE);
    assign bus.r1        = r1_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, handshake corner sequences and
// random ops against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int LEN = 16;
    localparam int SHW = $clog2(LEN);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.LEN(LEN), .SHW(SHW)) bus ();

    alu_seq #(.LEN(LEN), .SHW(SHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]     op;
        logic [LEN-1:0] a;
        logic [LEN-1:0] b;
        logic [SHW-1:0] sh;
        logic [LEN-1:0] r;
        logic [3:0]     f;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model from plain integer arithmetic on the operation rules
    function automatic void model(input int op, input longint a, input longint b, input int sh,
                                  output longint r, output logic [3:0] f);
        longint m, sa, sb, t;
        logic n, z, c, v;
        m  = longint'(1) << LEN;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            0: begin
                t = a + b; r = t % m; c = (t >= m);
                t = sa + sb; v = (t > m / 2 - 1) || (t < -(m / 2));
            end
            1, 9: begin
                r = (a - b + m) % m; c = (a < b);
                t = sa - sb; v = (t > m / 2 - 1) || (t < -(m / 2));
            end
            2: begin t = a * b; r = t % m; c = (t >= m); end
            3: r = a | b;
            4: r = a & b;
            5: r = a ^ b;
            6: begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
            7: begin r = (a << sh) % m; c = (sh != 0) && (((a >> (LEN - sh)) & 1) == 1); end
            8: r = ((a >> sh) | (a << (LEN - sh))) % m;
            default: r = 0;
        endcase
        z = (r == 0);
        n = (r >= m / 2);
        if (op == 9) begin r = 0; n = 1'b0; end
        f = (op > 9) ? 4'b0000 : {n, z, c, v};
    endfunction

    // Issue one op starting on a negedge; returns result, flags and latency
    task automatic do_op(input logic [3:0] op, input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                         input logic [SHW-1:0] sh, output logic [LEN-1:0] r,
                         output logic [3:0] f, output int lat);
        int n = 0;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid   = 1'b1;
        bus.opcode     = op;
        bus.r2         = a;
        bus.r3         = b;
        bus.shift_bits = sh;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.r2         = ~a;
        bus.r3         = ~b;
        bus.opcode     = 4'hF;
        bus.shift_bits = ~sh;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 40);
        if (!bus.out_valid) check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
        r = bus.r1;
        f = bus.flags;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LEN-1:0] r;
        logic [3:0]     f;
        int             lat;
        longint         er;
        logic [3:0]     ef;

        tbl[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 4'b1001};
        tbl[1]  = '{OP_SUB, 16'h0003, 16'h0005, 4'd0, 16'hFFFE, 4'b1010};
        tbl[2]  = '{OP_CMP, 16'h0005, 16'h0005, 4'd0, 16'h0000, 4'b0100};
        tbl[3]  = '{OP_MUL, 16'h00FF, 16'h0003, 4'd0, 16'h02FD, 4'b0000};
        tbl[4]  = '{OP_MUL, 16'h0100, 16'h0100, 4'd0, 16'h0000, 4'b0110};
        tbl[5]  = '{OP_LSH, 16'h8001, 16'h0000, 4'd1, 16'h0002, 4'b0010};
        tbl[6]  = '{OP_RSH, 16'h0003, 16'h0000, 4'd1, 16'h0001, 4'b0010};
        tbl[7]  = '{OP_ROR, 16'h0001, 16'h0000, 4'd4, 16'h1000, 4'b0000};
        tbl[8]  = '{OP_LSH, 16'hABCD, 16'h0000, 4'd0, 16'hABCD, 4'b1000};
        tbl[9]  = '{OP_RSH, 16'h8001, 16'h0000, 4'd0, 16'h8001, 4'b1000};
        tbl[10] = '{4'd12,  16'h1234, 16'h5678, 4'd3, 16'h0000, 4'b0000};
        tbl[11] = '{OP_OR,  16'hF0F0, 16'h0F0F, 4'd0, 16'hFFFF, 4'b1000};
        tbl[12] = '{OP_AND, 16'hF0F0, 16'h0F0F, 4'd0, 16'h0000, 4'b0100};
        tbl[13] = '{OP_CMP, 16'h0003, 16'h0005, 4'd0, 16'h0000, 4'b0010};

        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.opcode     = '0;
        bus.r2         = '0;
        bus.r3         = '0;
        bus.shift_bits = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready",  64'(bus.in_ready),  64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_busy",      64'(bus.busy),      64'd0);
        check("reset_r1",        64'(bus.r1),        64'd0);
        check("reset_flags",     64'(bus.flags),     64'd0);

        foreach (tbl[i]) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, r, f, lat);
            check($sformatf("vec%0d_r1", i),    64'(r),   64'(tbl[i].r));
            check($sformatf("vec%0d_flags", i), 64'(f),   64'(tbl[i].f));
            check($sformatf("vec%0d_lat", i),   64'(lat), (tbl[i].op == OP_MUL) ? 64'(LEN + 1) : 64'd1);
        end

        // Back-pressure: result held, second request ignored until retire
        do_op(OP_ADD, 16'h1234, 16'h1111, 4'd0, r, f, lat);
        bus.in_valid = 1'b1;
        bus.opcode   = OP_ADD;
        bus.r2       = 16'h1234;
        bus.r3       = 16'h1111;
        @(posedge clk);
        #1;
        bus.opcode   = OP_XOR;
        bus.r2       = 16'hFFFF;
        bus.r3       = 16'h00FF;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
            check("bp_r1",        64'(bus.r1),        64'h2345);
            check("bp_flags",     64'(bus.flags),     64'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_retire_out_valid", 64'(bus.out_valid), 64'd0);
        check("bp_retire_in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_next_r1",        64'(bus.r1),        64'hFF00);
        check("bp_next_flags",     64'(bus.flags),     64'b1000);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset in MUL cycle 8 discards the operation
        do_op(OP_ADD, 16'h0001, 16'h0001, 4'd0, r, f, lat);
        check("pre_rst_r1", 64'(r), 64'd2);
        bus.in_valid = 1'b1;
        bus.opcode   = OP_MUL;
        bus.r2       = 16'h0123;
        bus.r3       = 16'h0045;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("mul_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mul_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mul_r1",        64'(bus.r1),        64'd0);
        check("rst_mul_flags",     64'(bus.flags),     64'd0);
        check("rst_mul_busy",      64'(bus.busy),      64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mul_in_ready",  64'(bus.in_ready),  64'd1);
        do_op(OP_MUL, 16'h0123, 16'h0045, 4'd0, r, f, lat);
        check("post_rst_mul_r1",  64'(r),   64'h4E6F);
        check("post_rst_mul_lat", 64'(lat), 64'(LEN + 1));

        // Random ops against the model
        for (int i = 0; i < 150; i++) begin
            logic [3:0]     op;
            logic [LEN-1:0] a, b;
            logic [SHW-1:0] sh;
            op = 4'($urandom_range(0, 15));
            a  = LEN'($urandom);
            b  = LEN'($urandom);
            sh = SHW'($urandom);
            if (i % 4 == 0) b = LEN'($urandom_range(0, 7));
            if (i % 7 == 0) sh = '0;
            model(int'(op), longint'(a), longint'(b), int'(sh), er, ef);
            do_op(op, a, b, sh, r, f, lat);
            check($sformatf("rnd%0d_op%0d_r1", i, op),    64'(r),   64'(er));
            check($sformatf("rnd%0d_op%0d_flags", i, op), 64'(f),   64'(ef));
            check($sformatf("rnd%0d_op%0d_lat", i, op),   64'(lat), (op == OP_MUL) ? 64'(LEN + 1) : 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, sequential successor to the 16-bit combinational ALU. It accepts one operation per valid/ready handshake and returns a registered result and flags through a second valid/ready handshake. Single-cycle operations complete one cycle after acceptance. MUL runs as an iterative shift-add over LEN cycles, and CMP produces flags only. It sits between the register-file read stage and writeback, with back-pressure from writeback.

## Interface
- LEN, 16: datapath width; must be a power of two, ≥ 4.
- SHW, $clog2(LEN): shift-amount width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only in IDLE.
- opcode  in  4  operation select (see Operation).
- r2  in  LEN  operand A; also the shift/rotate source.
- r3  in  LEN  operand B.
- shift_bits  in  SHW  shift/rotate amount.
- out_valid  out  1  r1/flags hold a completed result.
- out_ready  in  1  consumer takes the result.
- r1  out  LEN  result.
- flags  out  4  {N, Z, C, V} = flags[3:0].
- busy  out  1  high in MUL or DONE.

## Operation
- Opcodes:
  - 0 ADD.
  - 1 SUB (r2−r3).
  - 2 MUL (low LEN bits).
  - 3 OR.
  - 4 AND.
  - 5 XOR.
  - 6 RSH (logical right shift).
  - 7 LSH.
  - 8 ROR.
  - 9 CMP (SUB flags, r1=0).
  - 10–15 undefined: r1=0, flags=0, 1-cycle latency.
- Operands, opcode and shift_bits are captured only at acceptance (in_valid && in_ready). Changes while busy are ignored.
- States:
  - IDLE: in_ready=1. On accept, MUL → MUL with counter=LEN. Any other opcode → compute combinationally, register r1/flags, → DONE.
  - MUL: one multiplier bit per cycle; counter decrements. At counter=1, → DONE with registered result.
  - DONE: out_valid=1; r1/flags held stable. On out_ready → IDLE (out_valid drops next cycle).
- N = r1[LEN-1]. Z = (r1==0), except CMP, where Z is computed from the difference. C and V per opcode:
  - ADD: C = carry out; V = signed overflow.
  - SUB/CMP: C = borrow (r2 <u r3); V = signed overflow.
  - MUL: C = 1 if upper LEN bits of the full 2·LEN product are nonzero; V = 0.
  - OR/AND/XOR: C = V = 0.
  - LSH: C = r2[LEN-shift_bits].
  - RSH: C = r2[shift_bits-1].
  - ROR: C = 0. V = 0 for all shifts and rotates.
  - shift_bits=0 → r1=r2, C=0.
- Reset asserted in any state, including mid-MUL:
  - next edge → IDLE; r1=0, flags=0, out_valid=0, busy=0, counter=0.
  - in_ready=1 the cycle after rst deasserts.
  - in-flight operation discarded.
- Simultaneous out_ready and in_valid in DONE: result retires, and the request is not accepted (in_ready=0 in DONE). It is accepted the following cycle in IDLE.

## Timing
- Accept at edge T:
  - single-cycle opcodes: out_valid=1 from T+1.
  - MUL: out_valid=1 from T+LEN+1.
- Result remains valid until the edge where out_valid && out_ready.
- Peak throughput: one op per 2 cycles (single-cycle) or LEN+2 cycles (MUL).
- Reset values: in_ready=1 (after reset), out_valid=0, busy=0, r1=0, flags=0.
- No combinational path from in_* to out_*. No combinational path from out_ready to in_ready.

## Structure
- Shared package alu_pkg:
  - opcode localparams (OP_ADD … OP_CMP).
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - state encoding (S_IDLE, S_MUL, S_DONE).
- Sub-module alu_mul_seq: iterative shift-add multiplier.
  - start, operands, 2·LEN accumulator, done pulse.
  - parametrised by LEN.
- Single-cycle datapath and flag logic: one case statement in alu_seq.
- Expected size: ~250 lines of RTL total.

## Test plan
(LEN=16)
- ADD 0x7FFF + 0x0001 → r1=0x8000, flags N=1 Z=0 C=0 V=1; out_valid exactly at T+1.
- SUB 0x0003 − 0x0005 → r1=0xFFFE, N=1 C=1 V=0. CMP 0x0005, 0x0005 → r1=0x0000, Z=1 C=0.
- MUL 0x00FF × 0x0003 → r1=0x02FD, C=0, out_valid at T+17. MUL 0x0100 × 0x0100 → r1=0x0000, Z=1 C=1.
- LSH 0x8001 by 1 → r1=0x0002, C=1. RSH 0x0003 by 1 → r1=0x0001, C=1. ROR 0x0001 by 4 → r1=0x1000, C=0. Any shift by 0 → r1=r2, C=0.
- Back-pressure: hold out_ready=0 for 5 cycles after a result. Required: r1/flags/out_valid stable, in_ready=0, a second in_valid ignored; after out_ready, the next op is accepted and its result is correct.
- rst asserted in MUL cycle 8 → next cycle out_valid=0, r1=0, flags=0, busy=0; in_ready=1 after deassert. Opcode 12 → r1=0, flags=0 at T+1.
